// File: rtl/stereo_channel_sequencer.sv
// Stereo channel sequencer: holds a left/right sample pair on the mux inputs,
// walks the mux select left then right with a settle gap after each select
// change, and hands each channel downstream with valid/ready. A one-deep
// pending buffer absorbs a pair offered while the current pair is in flight.
module stereo_channel_sequencer #(
  parameter int WIDTH  = 18,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] left_in,
  input  logic [WIDTH-1:0] right_in,
  input  logic             pair_valid,
  output logic             pair_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             sel,
  output logic             chan_valid,
  input  logic             chan_ready,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [2:0] {IDLE, SET_L, LEFT, SET_R, RIGHT} state_t;

  // Last count value of a settle gap; unused when SETTLE is zero.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE == 0 ? 0 : SETTLE - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       cnt;
  logic [3:0]       cnt_next;
  logic [WIDTH-1:0] pend_l;
  logic [WIDTH-1:0] pend_r;
  logic             pend_full;
  logic             pend_full_next;
  logic             pend_capture;
  logic             accept;
  logic             avail;
  logic             hs;
  logic             load;

  assign accept = pair_valid && pair_ready;
  assign avail  = pend_full || accept;
  assign hs     = chan_valid && chan_ready;

  // A pair arriving while nothing is being loaded (or while the pending
  // buffer is the load source) is parked in the pending buffer.
  assign pend_capture   = accept && (!load || pend_full);
  assign pend_full_next = load ? (pend_full && accept) : (pend_full || accept);

  // Next-state logic: select sequencing, settle counting and load decisions.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
          load       = 1'b1;
          state_next = (SETTLE == 0) ? LEFT : SET_L;
          cnt_next   = 4'd0;
        end
      end
      SET_L: begin
        if (cnt == SETTLE_LAST) state_next = LEFT;
        else                    cnt_next   = cnt + 4'd1;
      end
      LEFT: begin
        if (hs) begin
          state_next = (SETTLE == 0) ? RIGHT : SET_R;
          cnt_next   = 4'd0;
        end
      end
      SET_R: begin
        if (cnt == SETTLE_LAST) state_next = RIGHT;
        else                    cnt_next   = cnt + 4'd1;
      end
      RIGHT: begin
        if (hs) begin
          if (avail) begin
            load       = 1'b1;
            state_next = (SETTLE == 0) ? LEFT : SET_L;
            cnt_next   = 4'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sel        <= 1'b0;
      chan_valid <= 1'b0;
      busy       <= 1'b0;
      pair_ready <= 1'b1;
      pend_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sel        <= (state_next == SET_R) || (state_next == RIGHT);
      chan_valid <= (state_next == LEFT) || (state_next == RIGHT);
      busy       <= (state_next != IDLE);
      pair_ready <= !pend_full_next;
      pend_full  <= pend_full_next;
      if (pair_valid && !pair_ready) overflow <= 1'b1;
    end
  end

  // Sample holding registers: mux inputs change only on a load; the pending
  // buffer takes priority over the incoming pair as the load source.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out  <= '0;
      b_out  <= '0;
      pend_l <= '0;
      pend_r <= '0;
    end else begin
      if (load) begin
        a_out <= pend_full ? pend_l : left_in;
        b_out <= pend_full ? pend_r : right_in;
      end
      if (pend_capture) begin
        pend_l <= left_in;
        pend_r <= right_in;
      end
    end
  end

endmodule

// File: tb/tb_stereo_channel_sequencer.sv
// Bench for stereo_channel_sequencer: vector table for the single-pair
// sequence, hand sequences for stall/overflow/reset corners, a SETTLE=0
// instance for continuous streaming, and a randomized run against a
// queue-based reference model.
module tb_stereo_channel_sequencer;

  localparam int SETTLE_TB = 1;

  logic        clk;
  logic        rst_n;
  logic [17:0] left_in;
  logic [17:0] right_in;
  logic        pair_valid;
  logic        pair_ready;
  logic [17:0] a_out;
  logic [17:0] b_out;
  logic        sel;
  logic        chan_valid;
  logic        chan_ready;
  logic        busy;
  logic        overflow;

  logic        rst_n0;
  logic [17:0] left_in0;
  logic [17:0] right_in0;
  logic        pair_valid0;
  logic        pair_ready0;
  logic [17:0] a_out0;
  logic [17:0] b_out0;
  logic        sel0;
  logic        chan_valid0;
  logic        chan_ready0;
  logic        busy0;
  logic        overflow0;

  stereo_channel_sequencer #(.WIDTH(18), .SETTLE(SETTLE_TB)) dut (
    .clk(clk), .rst_n(rst_n), .left_in(left_in), .right_in(right_in),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .a_out(a_out),
    .b_out(b_out), .sel(sel), .chan_valid(chan_valid), .chan_ready(chan_ready),
    .busy(busy), .overflow(overflow)
  );

  stereo_channel_sequencer #(.WIDTH(18), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .left_in(left_in0), .right_in(right_in0),
    .pair_valid(pair_valid0), .pair_ready(pair_ready0), .a_out(a_out0),
    .b_out(b_out0), .sel(sel0), .chan_valid(chan_valid0), .chan_ready(chan_ready0),
    .busy(busy0), .overflow(overflow0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pairs held by the block (current first, then pending),
  // which half of the current pair is on offer, and cycles since the last
  // select change.
  typedef struct packed {
    logic [17:0] l;
    logic [17:0] r;
  } pair_t;

  pair_t       q[$];
  pair_t       cur;
  logic        half;
  int          since;
  logic        ovf;
  logic        live;
  logic [17:0] seen[$];
  int          nchan;

  task automatic cyc(input logic pv, input logic [17:0] l, input logic [17:0] r,
                     input logic cr, input logic rn);
    pair_t       np;
    logic        m_pr;
    logic        m_cv;
    logic        acc;
    logic        hs;
    logic [17:0] v;
    pair_valid = pv;
    left_in    = l;
    right_in   = r;
    chan_ready = cr;
    rst_n      = rn;
    m_pr = (q.size() < 2);
    m_cv = (q.size() > 0) && (since >= SETTLE_TB);
    if (live) begin
      chk("pair_ready", 32'(pair_ready), 32'(m_pr));
      chk("busy",       32'(busy),       32'(q.size() > 0));
      chk("chan_valid", 32'(chan_valid), 32'(m_cv));
      chk("sel",        32'(sel),        32'(half));
      chk("a_out",      32'(a_out),      32'(cur.l));
      chk("b_out",      32'(b_out),      32'(cur.r));
      chk("overflow",   32'(overflow),   32'(ovf));
    end
    if (rn && chan_valid && cr) begin
      v = sel ? b_out : a_out;
      seen.push_back(v);
      $display("chan %0d: sel=%0d data=%05h", nchan, sel, v);
      nchan++;
    end
    acc  = pv && m_pr;
    hs   = m_cv && cr;
    np.l = l;
    np.r = r;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      cur   = '0;
      half  = 1'b0;
      since = 0;
      ovf   = 1'b0;
      live  = 1'b1;
    end else begin
      if (pv && !m_pr) ovf = 1'b1;
      if (hs) begin
        if (!half) begin
          half = 1'b1;
        end else begin
          void'(q.pop_front());
          half = 1'b0;
          if (q.size() > 0) cur = q[0];
        end
        since = 0;
      end else if (since < 100) begin
        since++;
      end
      if (acc) begin
        q.push_back(np);
        if (q.size() == 1) begin
          cur   = np;
          half  = 1'b0;
          since = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        pv;
    logic [17:0] l;
    logic [17:0] r;
    logic        cr;
    logic        e_sel;
    logic        e_cv;
    logic        e_busy;
    logic        e_pr;
    logic [17:0] e_a;
    logic [17:0] e_b;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n0;
    rst_n = 1'b0; pair_valid = 1'b0; left_in = '0; right_in = '0; chan_ready = 1'b0;
    rst_n0 = 1'b0; pair_valid0 = 1'b0; left_in0 = '0; right_in0 = '0; chan_ready0 = 1'b1;
    q.delete(); cur = '0; half = 1'b0; since = 0; ovf = 1'b0; live = 1'b0; nchan = 0;

    //              pv    L          R          cr   sel  cv   busy pr   a          b
    tbl[0] = '{1'b0, 18'h0,     18'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h0,     18'h0};
    tbl[1] = '{1'b1, 18'h12345, 18'h2ABCD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h0,     18'h0};
    tbl[2] = '{1'b0, 18'h0,     18'h0,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 18'h12345, 18'h2ABCD};
    tbl[3] = '{1'b0, 18'h0,     18'h0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 18'h12345, 18'h2ABCD};
    tbl[4] = '{1'b0, 18'h0,     18'h0,     1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 18'h12345, 18'h2ABCD};
    tbl[5] = '{1'b0, 18'h0,     18'h0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h12345, 18'h2ABCD};
    tbl[6] = '{1'b0, 18'h0,     18'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h12345, 18'h2ABCD};

    @(negedge clk);
    cyc(1'b0, 18'h0, 18'h0, 1'b0, 1'b0);
    cyc(1'b0, 18'h0, 18'h0, 1'b0, 1'b0);

    // Reset state and a single pair, row by row
    chk("t1_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t2_sel[%0d]", i),  32'(sel),        32'(tbl[i].e_sel));
      chk($sformatf("t2_cv[%0d]", i),   32'(chan_valid), 32'(tbl[i].e_cv));
      chk($sformatf("t2_busy[%0d]", i), 32'(busy),       32'(tbl[i].e_busy));
      chk($sformatf("t2_pr[%0d]", i),   32'(pair_ready), 32'(tbl[i].e_pr));
      chk($sformatf("t2_a[%0d]", i),    32'(a_out),      32'(tbl[i].e_a));
      chk($sformatf("t2_b[%0d]", i),    32'(b_out),      32'(tbl[i].e_b));
      cyc(tbl[i].pv, tbl[i].l, tbl[i].r, tbl[i].cr, 1'b1);
    end

    // Downstream stall during LEFT
    cyc(1'b1, 18'h00111, 18'h00222, 1'b0, 1'b1);
    cyc(1'b0, 18'h0, 18'h0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("t3_cv",  32'(chan_valid), 32'd1);
      chk("t3_sel", 32'(sel),        32'd0);
      chk("t3_a",   32'(a_out),      32'h00111);
      cyc(1'b0, 18'h0, 18'h0, 1'b0, 1'b1);
    end
    repeat (4) cyc(1'b0, 18'h0, 18'h0, 1'b1, 1'b1);
    chk("t3_idle", 32'(busy), 32'd0);

    // Three pairs back to back: pending fills, third is dropped
    seen.delete();
    cyc(1'b1, 18'h01001, 18'h02001, 1'b1, 1'b1);
    cyc(1'b1, 18'h01002, 18'h02002, 1'b1, 1'b1);
    chk("t4_pr_low", 32'(pair_ready), 32'd0);
    chk("t4_ovf0",   32'(overflow),   32'd0);
    cyc(1'b1, 18'h01003, 18'h02003, 1'b1, 1'b1);
    chk("t4_ovf1",   32'(overflow),   32'd1);
    repeat (12) cyc(1'b0, 18'h0, 18'h0, 1'b1, 1'b1);
    chk("t4_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("t4_L1", 32'(seen[0]), 32'h01001);
      chk("t4_R1", 32'(seen[1]), 32'h02001);
      chk("t4_L2", 32'(seen[2]), 32'h01002);
      chk("t4_R2", 32'(seen[3]), 32'h02002);
    end

    // Reset while in RIGHT with the pending buffer full
    cyc(1'b1, 18'h03001, 18'h04001, 1'b1, 1'b1);
    cyc(1'b1, 18'h03002, 18'h04002, 1'b1, 1'b1);
    cyc(1'b0, 18'h0, 18'h0, 1'b1, 1'b1);
    cyc(1'b0, 18'h0, 18'h0, 1'b1, 1'b1);
    chk("t6_sel_right", 32'(sel),        32'd1);
    chk("t6_cv_right",  32'(chan_valid), 32'd1);
    chk("t6_pend_full", 32'(pair_ready), 32'd0);
    cyc(1'b0, 18'h0, 18'h0, 1'b1, 1'b0);
    chk("t6_a",    32'(a_out),      32'd0);
    chk("t6_b",    32'(b_out),      32'd0);
    chk("t6_cv",   32'(chan_valid), 32'd0);
    chk("t6_busy", 32'(busy),       32'd0);
    chk("t6_ovf",  32'(overflow),   32'd0);
    chk("t6_pr",   32'(pair_ready), 32'd1);
    n0 = seen.size();
    repeat (10) cyc(1'b0, 18'h0, 18'h0, 1'b1, 1'b1);
    chk("t6_no_stale", 32'(seen.size()), 32'(n0));

    // SETTLE=0 instance streaming continuously
    rst_n0 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      pair_valid0 = 1'b1;
      left_in0    = 18'(k);
      right_in0   = 18'(k + 100);
      chan_ready0 = 1'b1;
      if (k >= 1) begin
        chk("t5_cv",   32'(chan_valid0), 32'd1);
        chk("t5_sel",  32'(sel0),        32'((k - 1) % 2));
        chk("t5_pair", 32'(b_out0),      32'(a_out0 + 18'd100));
      end
      @(posedge clk);
      @(negedge clk);
    end
    pair_valid0 = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 45, 18'($urandom), 18'($urandom),
          $urandom_range(0, 99) < 70, $urandom_range(0, 299) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
